// File: rtl/bus_bit_scanner_if.sv
// ============================================================================
// Module      : bus_bit_scanner_if
// Description : Handshake bundle for bus_bit_scanner. Carries the input word
//               channel (in / in_valid / in_ready) and the index output
//               channel (out_index / out_valid / out_ready / out_last).
// Ports       : (interface signals)
//   in         BUS_WIDTH    word to scan
//   in_valid   1            producer holds a word
//   in_ready   1            scanner accepts a word this cycle
//   out_index  INDEX_WIDTH  lowest still-pending set bit
//   out_valid  1            out_index is meaningful
//   out_ready  1            consumer takes out_index this cycle
//   out_last   1            current index is the final pending bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_bit_scanner_if #(
  parameter int BUS_WIDTH   = 32,
  parameter int INDEX_WIDTH = 5
);
  logic [BUS_WIDTH-1:0]   in;
  logic                   in_valid;
  logic                   in_ready;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  // Scanner side
  modport slave (
    input  in,
    input  in_valid,
    output in_ready,
    output out_index,
    output out_valid,
    input  out_ready,
    output out_last
  );

  // Producer/consumer side
  modport master (
    output in,
    output in_valid,
    input  in_ready,
    input  out_index,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

`default_nettype wire

// File: rtl/bus_bit_scanner.sv
// ============================================================================
// Module      : bus_bit_scanner
// Description : Captures a bus word and emits the index of every set bit,
//               lowest index first, one index per output handshake. A zero
//               word is accepted and discarded without producing output.
// Ports       :
//   clk    input   single clock, rising edge
//   rst_n  input   asynchronous active-low reset
//   bus    slave   bus_bit_scanner_if (word in, index out handshakes)
// Parameters  :
//   BUS_WIDTH    width of the scanned word (>= 2)
//   INDEX_WIDTH  ceil(log2(BUS_WIDTH))
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_bit_scanner #(
  parameter int BUS_WIDTH   = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  bus_bit_scanner_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [BUS_WIDTH-1:0] c_one = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   pending_q, pending_d;

  logic [INDEX_WIDTH-1:0] w_low_idx;
  logic [BUS_WIDTH-1:0]   w_pending_drop_low;
  logic                   w_single;
  logic                   w_out_valid;
  logic                   w_out_last;
  logic                   w_in_ready;
  logic                   w_out_fire;
  logic                   w_in_fire;

  // Priority encoder: scan downward so the lowest set bit is written last.
  always_comb begin
    w_low_idx = '0;
    for (int i = BUS_WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        w_low_idx = INDEX_WIDTH'(i);
      end
    end
  end

  // x & (x-1) clears the lowest set bit; a zero result means one bit was set.
  assign w_pending_drop_low = pending_q & (pending_q - c_one);
  assign w_single           = (w_pending_drop_low == '0);

  // Outputs come only from registered state.
  assign w_out_valid = (state_q == SCAN);
  assign w_out_last  = w_out_valid & w_single;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  // Final-beat overlap lets a new word enter with no bubble.
  assign w_in_ready  = (state_q == IDLE) | (w_out_valid & w_out_last & bus.out_ready);
  assign w_in_fire   = bus.in_valid & w_in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;

    if (w_out_fire) begin
      pending_d = w_pending_drop_low;
      if (w_out_last) begin
        state_d = IDLE;
      end
    end

    // A new word overrides the drain result (only possible on the last beat
    // or in IDLE, where the drained value is zero anyway).
    if (w_in_fire) begin
      if (bus.in != '0) begin
        pending_d = bus.in;
        state_d   = SCAN;
      end else begin
        pending_d = '0;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_index = w_out_valid ? w_low_idx : '0;
  assign bus.out_last  = w_out_last;
  assign bus.in_ready  = w_in_ready;

endmodule

`default_nettype wire

// File: tb/tb_bus_bit_scanner.sv
// ============================================================================
// Module      : tb_bus_bit_scanner
// Description : Self-checking bench for bus_bit_scanner. Per-cycle vector
//               table plus hand-written reset-mid-scan and all-ones sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_bit_scanner;

  localparam int BW = 32;
  localparam int IW = 5;

  logic clk;
  logic rst_n;

  bus_bit_scanner_if #(.BUS_WIDTH(BW), .INDEX_WIDTH(IW)) bif ();

  bus_bit_scanner #(.BUS_WIDTH(BW), .INDEX_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = one clock cycle: inputs driven, outputs expected that cycle.
  typedef struct {
    logic          iv;
    logic [BW-1:0] din;
    logic          ordy;
    logic          e_ov;
    logic [IW-1:0] e_idx;
    logic          e_last;
    logic          e_ir;
  } vec_t;

  vec_t vq[$];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic [IW-1:0] idx,
                            input logic last, input logic ir);
    check({tag, "_out_valid"}, 32'(bif.out_valid), 32'(ov));
    check({tag, "_out_index"}, 32'(bif.out_index), 32'(idx));
    check({tag, "_out_last"},  32'(bif.out_last),  32'(last));
    check({tag, "_in_ready"},  32'(bif.in_ready),  32'(ir));
  endtask

  // Called at posedge+1; outputs checked at posedge+3, then advance one edge.
  task automatic apply(input vec_t v, input string tag);
    bif.in_valid  = v.iv;
    bif.in        = v.din;
    bif.out_ready = v.ordy;
    #2;
    check_outs(tag, v.e_ov, v.e_idx, v.e_last, v.e_ir);
    @(posedge clk); #1;
  endtask

  task automatic add(input logic iv, input logic [BW-1:0] din, input logic ordy,
                     input logic ov, input logic [IW-1:0] idx, input logic last, input logic ir);
    vec_t v;
    v.iv = iv; v.din = din; v.ordy = ordy;
    v.e_ov = ov; v.e_idx = idx; v.e_last = last; v.e_ir = ir;
    vq.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Single bit 0: accepted, then one last beat with in_ready high.
    add(1, 32'h0000_0001, 1,  0, 0, 0, 1);
    add(0, 32'h0,         1,  1, 0, 1, 1);
    // 0x80000011 -> 0, 4, 31.
    add(1, 32'h8000_0011, 1,  0, 0, 0, 1);
    add(0, 32'hFFFF_FFFF, 1,  1, 0, 0, 0);
    add(0, 32'h0,         1,  1, 4, 0, 0);
    add(0, 32'h0,         1,  1, 31, 1, 1);
    // Zero word is swallowed, then 0x100 -> 8.
    add(1, 32'h0000_0000, 1,  0, 0, 0, 1);
    add(1, 32'h0000_0100, 1,  0, 0, 0, 1);
    add(0, 32'h0,         1,  1, 8, 1, 1);
    // Backpressure on 0x30; in changes after capture must not matter.
    add(1, 32'h0000_0030, 0,  0, 0, 0, 1);
    for (int k = 0; k < 5; k++) add(0, 32'hFFFF_FFFF, 0, 1, 4, 0, 0);
    add(0, 32'h0,         1,  1, 4, 0, 0);
    add(0, 32'h0,         1,  1, 5, 1, 1);
    // Back-to-back 0x3 then 0x4: second word taken on the index-1 beat.
    add(1, 32'h0000_0003, 1,  0, 0, 0, 1);
    add(1, 32'h0000_0004, 1,  1, 0, 0, 0);
    add(1, 32'h0000_0004, 1,  1, 1, 1, 1);
    add(0, 32'h0,         1,  1, 2, 1, 1);
    // Top bit alone.
    add(1, 32'h8000_0000, 1,  0, 0, 0, 1);
    add(0, 32'h0,         1,  1, 31, 1, 1);
    add(0, 32'h0,         1,  0, 0, 0, 1);

    // Reset state.
    rst_n = 1'b0;
    bif.in_valid = 1'b0;
    bif.in = '0;
    bif.out_ready = 1'b0;
    #3;
    check_outs("reset", 0, 0, 0, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int r = 0; r < vq.size(); r++) begin
      apply(vq[r], $sformatf("row%0d", r));
    end

    // Reset mid-scan on 0xF0 after the index-4 beat.
    bif.in_valid = 1'b1; bif.in = 32'h0000_00F0; bif.out_ready = 1'b1;
    #2; check("mid_accept_in_ready", 32'(bif.in_ready), 32'd1);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    #2; check_outs("mid_beat4", 1, 4, 0, 0);
    @(posedge clk); #1;
    #1; check_outs("mid_beat5_pre", 1, 5, 0, 0);
    rst_n = 1'b0;
    bif.in_valid = 1'b1; bif.in = 32'h0000_00FF;
    #1; check_outs("mid_async_rst", 0, 0, 0, 1);
    @(posedge clk); @(posedge clk); #1;
    check("mid_rst_held_valid", 32'(bif.out_valid), 32'd0);
    bif.in_valid = 1'b0;
    rst_n = 1'b1;
    #2; check_outs("mid_after_rel", 0, 0, 0, 1);
    @(posedge clk); #1;
    #2; check_outs("mid_no_resume", 0, 0, 0, 1);
    bif.in_valid = 1'b1; bif.in = 32'h0000_0006;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    #2; check_outs("fresh_b1", 1, 1, 0, 0);
    @(posedge clk); #1;
    #2; check_outs("fresh_b2", 1, 2, 1, 1);
    @(posedge clk); #1;

    // All-ones word drains 0..31 in consecutive cycles.
    bif.in_valid = 1'b1; bif.in = 32'hFFFF_FFFF; bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    for (int i = 0; i < BW; i++) begin
      #2;
      check_outs($sformatf("ones%0d", i), 1, IW'(i), (i == BW - 1), (i == BW - 1));
      @(posedge clk); #1;
    end
    #2; check_outs("ones_done", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_bit_scanner.md
# bus_bit_scanner

Sequential counterpart to the bus OR reduction. The OR gate collapses a bus into a single "any bit set" flag. This block takes a captured bus word and reports which bits are set: it emits the index of each set bit, lowest index first, one per handshake. It sits between request/flag aggregation logic and any consumer that services flags one at a time (interrupt dispatch, request arbitration).

## Interface

Parameters:
- BUS_WIDTH, 32, width of the scanned word; must be at least 2.
- INDEX_WIDTH, 5, width of the index output; must equal ceil(log2(BUS_WIDTH)).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  BUS_WIDTH  word to scan; sampled when in_valid and in_ready are both high.
- in_valid  input  1  `in` holds a word.
- in_ready  output  1  block accepts a word this cycle.
- out_index  output  INDEX_WIDTH  index of the lowest still-pending set bit.
- out_valid  output  1  out_index is meaningful.
- out_ready  input  1  consumer takes out_index this cycle.
- out_last  output  1  the current index is the final pending bit of the word.

## Operation

- State is a register `pending[BUS_WIDTH-1:0]` plus a two-state FSM: IDLE and SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accepting a nonzero word loads it into pending, then the FSM goes to SCAN.
  - Accepting a zero word consumes and discards it; the FSM stays in IDLE and nothing is emitted.
- SCAN:
  - out_valid=1.
  - out_index is the priority-encoded lowest set bit of pending.
  - out_last=1 exactly when pending has one bit set.
- On out_valid & out_ready in SCAN, the bit at out_index is cleared in pending.
  - If out_last was 1, the FSM returns to IDLE.
  - Otherwise it stays in SCAN with the next set bit.
- in_ready = (state==IDLE) | (out_valid & out_last & out_ready).
  - On the final beat, a new word may be accepted in the same cycle.
  - That new word replaces pending, and the FSM is in SCAN (nonzero word) or IDLE (zero word) the next cycle.
  - This is the only combinational path from an input to an output.
- out_index, out_valid and out_last depend only on registered state, never combinationally on inputs.
- out_index, out_last and out_valid stay stable while out_valid=1 and out_ready=0.
- `in` is captured once. Changes on `in` after acceptance have no effect.
- When out_valid=0, out_index and out_last are 0.

## Timing

- Reset (rst_n low, asynchronous): pending=0 and FSM=IDLE immediately.
  - Outputs during and after reset: out_valid=0, out_index=0, out_last=0, in_ready=1.
  - No handshakes are honoured while rst_n is low.
- Reset mid-scan: the remaining bits are dropped with no further beats. After rst_n rises, the block is in IDLE.
- Latency: a word accepted at edge k gives out_valid=1 in the cycle following edge k, carrying the lowest set index.
- Throughput: with out_ready held high, a word with N set bits drains in N consecutive cycles.
- Back-to-back words with in_valid held high have zero bubble cycles between words.
- Zero words cost one accept cycle each and produce no output.
- All-ones word: emits indices 0..BUS_WIDTH-1 in order; out_last is high only on index BUS_WIDTH-1.
- Bit BUS_WIDTH-1 alone: a single beat with index BUS_WIDTH-1 and out_last=1.

## Test plan

- Reset then in=32'h0000_0001 with out_ready=1 -> one beat: out_index=0, out_last=1; in_ready=1 on that same beat.
- in=32'h8000_0011, out_ready=1 -> out_index 0, 4, 31 on three consecutive cycles; out_last=0,0,1; in_ready=0 on the first two cycles, 1 on the third.
- in=32'h0000_0000 accepted -> out_valid stays 0 and in_ready stays 1; the next word 32'h0000_0100 yields out_index=8, out_last=1.
- Backpressure: in=32'h0000_0030, out_ready=0 for 5 cycles -> out_index=4, out_valid=1, out_last=0 held stable; then out_ready=1 -> 4 then 5 (last).
- Back-to-back: words 32'h3 then 32'h4 with in_valid high and out_ready=1 -> indices 0, 1, 2 on three consecutive cycles; the second word is accepted on the index-1 beat.
- Reset mid-scan: in=32'h0000_00F0, out_ready=1, rst_n driven low after the index-4 beat -> out_valid=0 asynchronously, with no index 5/6/7 emitted. After release, in_ready=1 and a fresh word scans normally.
